// File: rtl/iir_delay_line.sv
// iir_delay_line: run-time selectable z^-k delay line for the IIR datapath.
//
// The line advances only on the sample strobe, so delays are counted in
// accepted samples, not clocks. The selected tap is a combinational mux of
// the registered stages.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   en       sample strobe; accept d and advance the line
//   clr      synchronous flush of stages and fill count (wins over en)
//   d        input sample (WIDTH bits, treated as opaque)
//   dly      requested delay k; 0 -> 1, values above DEPTH -> DEPTH
//   q        sample delayed by the effective k accepted samples
//   q_valid  q holds a sample accepted since the last reset/clr
//   fill     accepted samples since reset/clr, saturating at DEPTH
//   taps     (only with IIR_DLY_TAPS_OUT_EN) all stages, stage i in
//            taps[WIDTH*(i+1)-1 -: WIDTH]
//
// Optional feature macro: IIR_DLY_TAPS_OUT_EN
module iir_delay_line #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic [WIDTH-1:0]       d,
  input  logic [DW-1:0]          dly,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
`ifdef IIR_DLY_TAPS_OUT_EN
  output logic [WIDTH*DEPTH-1:0] taps,
`endif
  output logic [DW-1:0]          fill
);

  localparam logic [DW-1:0] DEPTH_W = DW'(DEPTH);
  localparam logic [DW-1:0] ONE_W   = DW'(1);

  logic [WIDTH-1:0] sr_q [DEPTH];
  logic [WIDTH-1:0] sr_d [DEPTH];
  logic [DW-1:0]    fill_q;
  logic [DW-1:0]    fill_d;
  logic [DW-1:0]    ke;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) sr_d[i] = sr_q[i];
    fill_d = fill_q;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) sr_d[i] = '0;
      fill_d = '0;
    end else if (en) begin
      sr_d[0] = d;
      for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
      fill_d = (fill_q == DEPTH_W) ? fill_q : fill_q + ONE_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      fill_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= sr_d[i];
      fill_q <= fill_d;
    end
  end

  // Clamp the requested delay into 1..DEPTH; out-of-range is never an error.
  always_comb begin
    if (dly == '0)          ke = ONE_W;
    else if (dly > DEPTH_W) ke = DEPTH_W;
    else                    ke = dly;
  end

  // Compare-based mux keeps the index in range for every ke encoding.
  always_comb begin
    q = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ke == DW'(i + 1)) q = sr_q[i];
    end
  end

  assign q_valid = (fill_q >= ke);
  assign fill    = fill_q;

`ifdef IIR_DLY_TAPS_OUT_EN
  for (genvar g = 0; g < DEPTH; g++) begin : g_taps
    assign taps[WIDTH*(g+1)-1 -: WIDTH] = sr_q[g];
  end
`endif

endmodule

// File: tb/tb_iir_delay_line.sv
module tb_iir_delay_line;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int DW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] d;
  logic [DW-1:0]    dly;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [DW-1:0]    fill;
`ifdef IIR_DLY_TAPS_OUT_EN
  logic [WIDTH*DEPTH-1:0] taps;
`endif

  int checks   = 0;
  int failures = 0;

  iir_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .d       (d),
    .dly     (dly),
    .q       (q),
    .q_valid (q_valid),
`ifdef IIR_DLY_TAPS_OUT_EN
    .taps    (taps),
`endif
    .fill    (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: history of accepted samples, newest first.
  logic [WIDTH-1:0] hist [$];

  function automatic int eff_k(input int k);
    if (k == 0) return 1;
    if (k > DEPTH) return DEPTH;
    return k;
  endfunction

  task automatic model_edge(input logic e, input logic c, input logic [WIDTH-1:0] x);
    if (c) hist.delete();
    else if (e) begin
      hist.push_front(x);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    int k;
    logic [WIDTH-1:0] eq;
    k  = eff_k(int'(dly));
    eq = (k <= hist.size()) ? hist[k-1] : '0;
    chk({name, ".q"}, 64'(q), 64'(eq));
    chk({name, ".valid"}, 64'(q_valid), 64'(hist.size() >= k));
    chk({name, ".fill"}, 64'(fill), 64'(hist.size()));
  endtask

  task automatic step(input logic e, input logic c, input logic [WIDTH-1:0] x);
    en = e; clr = c; d = x;
    @(posedge clk);
    model_edge(e, c, x);
    #1;
    en = 1'b0; clr = 1'b0;
  endtask

  typedef struct {
    logic             e;
    logic             c;
    logic [WIDTH-1:0] x;
    logic [DW-1:0]    k;
    logic [WIDTH-1:0] exp_q;
    logic             exp_v;
    logic [DW-1:0]    exp_fill;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    // gapped enable, then clr+en priority, then a fresh sample
    vecs[0] = '{1'b1, 1'b0, 32'hA,  5'd2, 32'h0,  1'b0, 5'd1};
    vecs[1] = '{1'b0, 1'b0, 32'hF1, 5'd2, 32'h0,  1'b0, 5'd1};
    vecs[2] = '{1'b0, 1'b0, 32'hF2, 5'd2, 32'h0,  1'b0, 5'd1};
    vecs[3] = '{1'b1, 1'b0, 32'hB,  5'd2, 32'hA,  1'b1, 5'd2};
    vecs[4] = '{1'b0, 1'b0, 32'hF3, 5'd2, 32'hA,  1'b1, 5'd2};
    vecs[5] = '{1'b1, 1'b0, 32'hC,  5'd2, 32'hB,  1'b1, 5'd3};
    vecs[6] = '{1'b1, 1'b1, 32'h55, 5'd2, 32'h0,  1'b0, 5'd0};
    vecs[7] = '{1'b1, 1'b0, 32'h77, 5'd2, 32'h0,  1'b0, 5'd1};
    vecs[8] = '{1'b0, 1'b0, 32'h0,  5'd1, 32'h77, 1'b1, 5'd1};

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; d = '0; dly = 5'd1;
    #12;
    chk("reset.q", 64'(q), 64'h0);
    chk("reset.valid", 64'(q_valid), 64'h0);
    chk("reset.fill", 64'(fill), 64'h0);
    rst_n = 1'b1;

    // async reset mid-run
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, WIDTH'(i));
    chk("pre_rst.fill", 64'(fill), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    hist.delete();
    chk("async_rst.q", 64'(q), 64'h0);
    chk("async_rst.valid", 64'(q_valid), 64'h0);
    chk("async_rst.fill", 64'(fill), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 32'hDEAD);
      check_model("idle_after_rst");
    end

    // basic delay of 3
    dly = 5'd3;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0, WIDTH'(i));
      check_model("basic");
      if (i == 2) chk("basic.valid_before3", 64'(q_valid), 64'h0);
      if (i == 3) chk("basic.q_at_fill3", 64'(q), 64'd1);
      if (i == 4) chk("basic.q_next", 64'(q), 64'd2);
    end
    chk("basic.fill_sat", 64'(fill), 64'd16);

    // clamping and tap switch on a full line holding 5..20
    dly = 5'd0;  #1 chk("clamp.k0", 64'(q), 64'd20);
    dly = 5'd16; #1 chk("clamp.k16", 64'(q), 64'd5);
    dly = 5'd31; #1 chk("clamp.k31", 64'(q), 64'd5);
    chk("clamp.valid", 64'(q_valid), 64'h1);
    dly = 5'd15; #1 chk("clamp.k15", 64'(q), 64'd6);
    chk("clamp.valid15", 64'(q_valid), 64'h1);

    // table: gapped enable and clear priority
    step(1'b0, 1'b1, '0);
    for (int i = 0; i < 9; i++) begin
      dly = vecs[i].k;
      step(vecs[i].e, vecs[i].c, vecs[i].x);
      chk($sformatf("vec%0d.q", i), 64'(q), 64'(vecs[i].exp_q));
      chk($sformatf("vec%0d.valid", i), 64'(q_valid), 64'(vecs[i].exp_v));
      chk($sformatf("vec%0d.fill", i), 64'(fill), 64'(vecs[i].exp_fill));
    end

`ifdef IIR_DLY_TAPS_OUT_EN
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 32'd7);
    step(1'b1, 1'b0, 32'd8);
    step(1'b1, 1'b0, 32'd9);
    for (int i = 0; i < DEPTH; i++) begin
      logic [WIDTH-1:0] et;
      et = (i == 0) ? 32'd9 : (i == 1) ? 32'd8 : (i == 2) ? 32'd7 : 32'd0;
      chk($sformatf("taps%0d", i), 64'(taps[WIDTH*(i+1)-1 -: WIDTH]), 64'(et));
    end
`endif

    // randomized against the queue model, including mid-stream tap switches
    for (int i = 0; i < 400; i++) begin
      logic e, c;
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 40) == 0);
      dly = DW'($urandom_range(0, 31));
      step(e, c, $urandom);
      check_model("rand");
      dly = DW'($urandom_range(0, 31));
      #1;
      check_model("rand_switch");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iir_delay_line.md
Name: iir_delay_line

Overview:
- Parametrised z^-k delay line for the IIR datapath. It generalises the single 32-bit z^-1 register to a WIDTH-bit, DEPTH-stage shift line.
- Stages advance only on a sample-enable strobe, so the line runs at the filter sample rate rather than the clock rate.
- Delay k is selectable at run time. The block reports when the selected tap holds real data rather than reset fill.
- Sits between the adder/multiplier stages of the direct-form IIR sections, feeding the feedback and feedforward coefficient multipliers.

Parameters:
- WIDTH, 32, sample width in bits (two's complement; the block treats it as opaque bits).
- DEPTH, 16, number of stages (maximum delay); legal range DEPTH >= 1.
- DW, $clog2(DEPTH+1), width of the delay-select and fill-count fields (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  sample strobe; 1 = accept d and advance the line this cycle.
- clr  input  1  synchronous flush of all stages and fill count.
- d  input  WIDTH  input sample.
- dly  input  DW  requested delay k, in samples.
- q  output  WIDTH  sample delayed by k accepted samples.
- q_valid  output  1  1 when q holds a sample accepted since the last reset/clr.
- fill  output  DW  number of accepted samples since reset/clr, saturating at DEPTH.

Behaviour:
- Storage: stages sr[0..DEPTH-1], each WIDTH bits; fill counter is DW bits.
- Reset (rst_n=0, asynchronous): all sr[i]=0, fill=0, hence q=0 and q_valid=0. Release is synchronous to clk.
- Priority per rising edge: clr > en > hold.
- clr=1: all sr[i]<=0 and fill<=0, regardless of en. The sample on d that cycle is discarded.
- en=1, clr=0: sr[0]<=d, sr[i]<=sr[i-1] for i=1..DEPTH-1, and fill<=min(fill+1, DEPTH). The oldest stage is dropped.
- en=0, clr=0: all state holds.
- Effective delay: ke = 1 if dly=0; DEPTH if dly>DEPTH; otherwise dly. Out-of-range values are clamped, never an error.
- q = sr[ke-1], a combinational mux of registered stages; no extra register.
  - With ke=1, q equals the last accepted d, i.e. the classic one-sample delay in the en domain.
  - With en tied high, ke=1 gives exactly one clock of latency.
- Latency: a sample accepted on enable edge n appears on q immediately after enable edge n+ke-1.
- q_valid = (fill >= ke), combinational.
- Changing dly mid-stream: q and q_valid reflect the new tap in the same cycle. No state changes and no re-priming is needed.
- Fill saturation: fill stays at DEPTH once reached, and q_valid stays 1 for every ke until clr/reset.
- DEPTH=1: the block degenerates to a single enabled register. dly is then effectively ignored.
- No backpressure: en is never refused, and a full line simply discards its oldest sample.

Optional Feature:
- Macro: IIR_DLY_TAPS_OUT_EN.
- Defined: adds output port taps [WIDTH*DEPTH-1:0], with taps[WIDTH*(i+1)-1 -: WIDTH] = sr[i] for all i. It is purely combinational from the stages, so the transposed/FIR sections can read every delayed sample without instantiating multiple lines. Timing of q, q_valid and fill is unchanged.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
- Reset: drive rst_n=0 mid-run after 5 accepted samples → q=0, q_valid=0 and fill=0 immediately, without waiting for a clock edge. After release with en=0 for 10 cycles → all outputs unchanged.
- Basic delay (WIDTH=32, DEPTH=16): dly=3, en=1 every cycle, d=1,2,3,... → q_valid rises after the 3rd accepted sample; from then on q equals d from 3 accepted samples earlier (q=1 when fill=3, q=2 next). fill saturates at 16.
- Gapped enable: dly=2, en pattern 1,0,0,1,0,1 with d=0xA,x,x,0xB,x,0xC → q=0xA after the 2nd enable and holds through idle cycles. q=0xB after the 3rd enable.
- Clamping and tap switch: line full with d=1..20. dly=0 → q=20. dly=16 → q=5. dly=31 → q=5. Every switch takes effect the same cycle with q_valid=1.
- Clear priority: clr=1 and en=1 together with d=0x55 → next cycle fill=0, q=0, q_valid=0, and 0x55 is not stored.
- With IIR_DLY_TAPS_OUT_EN: after accepting 7,8,9 → taps slice 0=9, slice 1=8, slice 2=7, remaining slices 0.
